// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader slice.
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } loader_state_t;

  // Running modulo-256 sum over every data byte of a load.
  function automatic logic [7:0] checksumAdd(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in, memory write port out; master is the loader side.
interface prog_loader_if #(
  parameter int ADDR_W = 32
);

  logic                         in_valid;
  logic [7:0]                   in_data;
  logic                         in_ready;
  logic [ADDR_W-1:0]            mem_waddress;
  logic [loader_pkg::WORD_W-1:0] mem_datain;
  logic                         mem_wr;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_waddress, mem_datain, mem_wr
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_waddress, mem_datain, mem_wr
  );

endinterface

// File: rtl/prog_loader_word_asm.sv
// Little-endian byte-to-word assembler; the running checksum exists only
// when LOADER_CHECKSUM_EN is defined.
module loader_word_asm
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              clear,
  input  logic              take,
  input  logic [7:0]        inData,
  output logic              wordFull,
  output logic [WORD_W-1:0] word
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  logic [LANE_W-1:0] byteCnt;

  // High while the next accepted byte completes the word.
  assign wordFull = (byteCnt == LAST_LANE);

  // Lane shift register and byte counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      byteCnt <= {LANE_W{1'b0}};
      word    <= {WORD_W{1'b0}};
    end else if (clear) begin
      byteCnt <= {LANE_W{1'b0}};
      word    <= {WORD_W{1'b0}};
    end else if (take) begin
      word[{byteCnt, 3'b000} +: 8] <= inData;
      byteCnt                      <= byteCnt + 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running checksum over all data bytes of the current load.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      checksum <= 8'd0;
    end else if (clear) begin
      checksum <= 8'd0;
    end else if (take) begin
      checksum <= checksumAdd(checksum, inData);
    end
  end
`endif

endmodule

// File: rtl/prog_loader.sv
// Loads a byte stream into memory as little-endian words and holds the core in
// reset until the load succeeds. LOADER_CHECKSUM_EN adds a trailing checksum byte.
module prog_loader
  import loader_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 1024
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic [15:0]   len_words,
  prog_loader_if.master bus,
  output logic          core_rst,
  output logic          busy,
  output logic          done,
  output logic          err
);

  loader_state_t     state, nextState;
  logic [15:0]       lenR, lenNext, wordCnt, wordCntNext;
  logic [ADDR_W-1:0] addr, addrNext;
  logic              errR, errNext, coreRstR, coreRstNext;
  logic              inReadyR, memWrR, busyR, doneR;
  logic              xfer, takeData, clearAsm, wordFull, lenTooBig;
  logic [WORD_W-1:0] word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        checksum;
`endif

  assign xfer      = bus.in_valid && inReadyR;
  assign lenTooBig = ({16'd0, len_words} > MAX_WORDS);

  loader_word_asm uAsm (
    .clk      (clk),
    .nrst     (nrst),
    .clear    (clearAsm),
    .take     (takeData),
    .inData   (bus.in_data),
    .wordFull (wordFull),
    .word     (word)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  // Next-state and datapath control.
  always_comb begin
    nextState   = state;
    lenNext     = lenR;
    wordCntNext = wordCnt;
    addrNext    = addr;
    errNext     = errR;
    coreRstNext = coreRstR;
    clearAsm    = 1'b0;
    takeData    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          errNext     = 1'b0;
          lenNext     = len_words;
          addrNext    = BASE_ADDR;
          wordCntNext = 16'd0;
          clearAsm    = 1'b1;
          coreRstNext = 1'b1;
          if (len_words == 16'd0) begin
            nextState   = DONE;
            coreRstNext = 1'b0;
          end else if (lenTooBig) begin
            errNext   = 1'b1;
            nextState = DONE;
          end else begin
            nextState = RECV;
          end
        end else begin
          nextState = IDLE;
        end
      end
      RECV: begin
        if (xfer) begin
          takeData  = 1'b1;
          nextState = wordFull ? WRITE : RECV;
        end else begin
          nextState = RECV;
        end
      end
      WRITE: begin
        addrNext    = addr + ADDR_W'(32'd4);
        wordCntNext = wordCnt + 16'd1;
        if (wordCntNext == lenR) begin
`ifdef LOADER_CHECKSUM_EN
          nextState   = CHECK;
`else
          nextState   = DONE;
          coreRstNext = errR;
`endif
        end else begin
          nextState = RECV;
        end
      end
      CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (xfer) begin
          errNext     = (bus.in_data != checksum) ? 1'b1 : errR;
          coreRstNext = errNext;
          nextState   = DONE;
        end else begin
          nextState = CHECK;
        end
`else
        nextState = IDLE;
`endif
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State, counters and output registers; outputs decode the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      lenR     <= 16'd0;
      wordCnt  <= 16'd0;
      addr     <= BASE_ADDR;
      errR     <= 1'b0;
      coreRstR <= 1'b1;
      inReadyR <= 1'b0;
      memWrR   <= 1'b0;
      busyR    <= 1'b0;
      doneR    <= 1'b0;
    end else begin
      state    <= nextState;
      lenR     <= lenNext;
      wordCnt  <= wordCntNext;
      addr     <= addrNext;
      errR     <= errNext;
      coreRstR <= coreRstNext;
      inReadyR <= (nextState == RECV) || (nextState == CHECK);
      memWrR   <= (nextState == WRITE);
      busyR    <= (nextState != IDLE);
      doneR    <= (nextState == DONE);
    end
  end

  assign bus.in_ready     = inReadyR;
  assign bus.mem_waddress = addr;
  assign bus.mem_datain   = word;
  assign bus.mem_wr       = memWrR;
  assign core_rst         = coreRstR;
  assign busy             = busyR;
  assign done             = doneR;
  assign err              = errR;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; expectations follow LOADER_CHECKSUM_EN.
module tb_prog_loader;

  localparam int          ADDR_W    = 32;
  localparam int unsigned MAX_WORDS = 1024;
`ifdef LOADER_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic        clk      = 1'b0;
  logic        nrst     = 1'b1;
  logic        start    = 1'b0;
  logic [15:0] lenWords = 16'd0;
  logic        coreRst, busy, done, err;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int startCyc = 0;
  int doneLat  = 0;

  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (32'h0),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .len_words (lenWords),
    .bus       (bus),
    .core_rst  (coreRst),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.mem_wr === 1'b1) begin
      wrAddr.push_back(bus.mem_waddress);
      wrData.push_back(bus.mem_datain);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startLoad(input logic [15:0] len);
    start    = 1'b1;
    lenWords = len;
    tick();
    start    = 1'b0;
    lenWords = 16'hFFFF;
    startCyc = cyc;
  endtask

  task automatic sendByte(input logic [7:0] d, input int gap);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("ready_wait", (n < 100) ? 32'd1 : 32'd0, 32'd1);
    repeat (gap) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hEE;
  endtask

  task automatic waitDone();
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("done_wait", (n < 200) ? 32'd1 : 32'd0, 32'd1);
    doneLat = cyc - startCyc;
  endtask

  // Two-word program 13 00 00 00 93 00 10 00; a stray start mid-load must be ignored.
  task automatic sendProgram(input int gap);
    logic [7:0] prog [8];
    prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    wrAddr.delete();
    wrData.delete();
    startLoad(16'd2);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        start    = 1'b1;
        lenWords = 16'd0;
      end
      sendByte(prog[i], (i == 0) ? 0 : gap);
      start = 1'b0;
    end
  endtask

  task automatic checkProgWrites(input string tag);
    check({tag, "_wr_count"}, 32'(wrAddr.size()), 32'd2);
    if (wrAddr.size() == 2) begin
      check({tag, "_addr0"}, wrAddr[0], 32'h0000_0000);
      check({tag, "_data0"}, wrData[0], 32'h0000_0013);
      check({tag, "_addr1"}, wrAddr[1], 32'h0000_0004);
      check({tag, "_data1"}, wrData[1], 32'h0010_0093);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Power-on reset
    #2 nrst = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    check("rst_waddr", bus.mem_waddress, 32'h0);
    check("rst_datain", bus.mem_datain, 32'h0);
    check("rst_core_rst", 32'(coreRst), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    nrst = 1'b1;
    tick();

    // Normal load, valid held high
    sendProgram(0);
    check("norm_busy", 32'(busy), 32'd1);
    check("norm_core_rst_held", 32'(coreRst), 32'd1);
`ifdef LOADER_CHECKSUM_EN
    sendByte(8'hB6, 0);
`endif
    waitDone();
    check("norm_latency", 32'(doneLat), 32'(10 + CHK));
    check("norm_core_rst", 32'(coreRst), 32'd0);
    check("norm_err", 32'(err), 32'd0);
    tick();
    check("norm_done_pulse", 32'(done), 32'd0);
    check("norm_idle_busy", 32'(busy), 32'd0);
    checkProgWrites("norm");

    // Same stream with 3-cycle valid gaps before every byte after the first
    sendProgram(3);
`ifdef LOADER_CHECKSUM_EN
    sendByte(8'hB6, 3);
`endif
    waitDone();
    check("stall_latency", 32'(doneLat), 32'(10 + CHK + 3 * (7 + CHK)));
    check("stall_core_rst", 32'(coreRst), 32'd0);
    tick();
    checkProgWrites("stall");

    // Oversized length: rejected, no writes
    wrAddr.delete();
    wrData.delete();
    startLoad(16'(MAX_WORDS + 1));
    waitDone();
    check("big_latency", 32'(doneLat), 32'd0);
    check("big_err", 32'(err), 32'd1);
    check("big_core_rst", 32'(coreRst), 32'd1);
    tick();
    check("big_err_sticky", 32'(err), 32'd1);
    check("big_wr_count", 32'(wrAddr.size()), 32'd0);

    // Zero length clears err, releases the core; start during done is ignored
    startLoad(16'd0);
    waitDone();
    check("zero_latency", 32'(doneLat), 32'd0);
    check("zero_err", 32'(err), 32'd0);
    check("zero_core_rst", 32'(coreRst), 32'd0);
    start    = 1'b1;
    lenWords = 16'd1;
    tick();
    start = 1'b0;
    check("start_in_done_busy", 32'(busy), 32'd0);
    check("zero_wr_count", 32'(wrAddr.size()), 32'd0);

    // Asynchronous reset while err is set
    startLoad(16'hFFFF);
    waitDone();
    check("big2_err", 32'(err), 32'd1);
    nrst = 1'b0;
    #2;
    check("arst_err", 32'(err), 32'd0);
    check("arst_core_rst", 32'(coreRst), 32'd1);
    check("arst_in_ready", 32'(bus.in_ready), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    tick();
    nrst = 1'b1;
    tick();

    // Reset during the WRITE cycle drops mem_wr at once
    wrAddr.delete();
    wrData.delete();
    startLoad(16'd1);
    sendByte(8'h01, 0);
    sendByte(8'h02, 0);
    sendByte(8'h03, 0);
    sendByte(8'h04, 0);
    check("wr_cycle_mem_wr", 32'(bus.mem_wr), 32'd1);
    check("wr_cycle_data", bus.mem_datain, 32'h0403_0201);
    check("wr_cycle_addr", bus.mem_waddress, 32'h0);
    #2 nrst = 1'b0;
    #1;
    check("arst_wr_mem_wr", 32'(bus.mem_wr), 32'd0);
    check("arst_wr_datain", bus.mem_datain, 32'h0);
    check("arst_wr_core_rst", 32'(coreRst), 32'd1);
    tick();
    nrst = 1'b1;
    tick();
    check("arst_wr_count", 32'(wrAddr.size()), 32'd0);

    // Reset after two bytes, then a fresh one-word load
    startLoad(16'd1);
    sendByte(8'h11, 0);
    sendByte(8'h22, 0);
    nrst = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_core_rst", 32'(coreRst), 32'd1);
    tick();
    nrst = 1'b1;
    tick();
    wrAddr.delete();
    wrData.delete();
    startLoad(16'd1);
    sendByte(8'hAA, 0);
    sendByte(8'hBB, 0);
    sendByte(8'hCC, 0);
    sendByte(8'hDD, 0);
`ifdef LOADER_CHECKSUM_EN
    sendByte(8'h0E, 0);
`endif
    waitDone();
    check("fresh_latency", 32'(doneLat), 32'(5 + CHK));
    check("fresh_core_rst", 32'(coreRst), 32'd0);
    check("fresh_err", 32'(err), 32'd0);
    tick();
    check("fresh_wr_count", 32'(wrAddr.size()), 32'd1);
    if (wrAddr.size() == 1) begin
      check("fresh_addr", wrAddr[0], 32'h0);
      check("fresh_data", wrData[0], 32'hDDCC_BBAA);
    end

`ifdef LOADER_CHECKSUM_EN
    // Bad trailing checksum keeps the core in reset
    sendProgram(0);
    sendByte(8'hB5, 0);
    waitDone();
    check("badsum_err", 32'(err), 32'd1);
    check("badsum_core_rst", 32'(coreRst), 32'd1);
    tick();
    checkProgWrites("badsum");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
